// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the CLB configuration path: frame layout,
// flip-flop enable encodings and the loader state type.
package fpga_cfg_pkg;

    // Config frame width and field bounds
    localparam int FRAME_W     = 23;
    localparam int OUT_SEL_MSB = 22;
    localparam int OUT_SEL_LSB = 19;
    localparam int OMUX_BIT    = 18;
    localparam int FFEN_MSB    = 17;
    localparam int FFEN_LSB    = 16;
    localparam int LUT_MSB     = 15;
    localparam int LUT_LSB     = 0;

    // Flip-flop enable source encodings
    localparam logic [1:0] FFEN_LEFT   = 2'b00;
    localparam logic [1:0] FFEN_RIGHT  = 2'b01;
    localparam logic [1:0] FFEN_ALWAYS = 2'b10;
    localparam logic [1:0] FFEN_UP     = 2'b11;

    // Loader control states
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WRITE,
        DONE,
        ERROR
    } loader_state_e;

endpackage

// File: rtl/cfg_frame_shifter.sv
// Serial-to-parallel frame assembler. Shifts FRAME_W data bits MSB first,
// then consumes one odd-parity bit. frame_complete/parity_ok are valid in
// the same cycle as the parity transfer so the controller can act on it at
// the following edge.
module cfg_frame_shifter #(
    parameter int FRAME_W = fpga_cfg_pkg::FRAME_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_bit_en,
    input  logic               i_bit,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_frame_complete,
    output logic               o_parity_ok
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    logic [FRAME_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_parity;
    logic               w_parity_slot;

    assign w_parity_slot = (r_cnt == CNT_W'(FRAME_W));

    // Shift data bits in at the LSB; the parity slot only closes the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_parity <= 1'b0;
        end else if (i_bit_en) begin
            if (w_parity_slot) begin
                // NOTE: non-blocking assignments keep every register update
                // based on the pre-edge values, independent of statement order.
                r_cnt    <= '0;
                r_parity <= 1'b0;
            end else begin
                r_shift  <= {r_shift[FRAME_W-2:0], i_bit};
                r_cnt    <= r_cnt + 1'b1;
                r_parity <= r_parity ^ i_bit;
            end
        end
    end

    assign o_frame          = r_shift;
    assign o_frame_complete = i_bit_en & w_parity_slot;
    // Odd parity over data plus parity bit must come out as 1
    assign o_parity_ok      = r_parity ^ i_bit;

endmodule

// File: rtl/clb_config_loader.sv
// Configuration loader for the CLB array: receives a serial bitstream,
// checks each frame's parity and writes frames to CLB 0..N_CLB-1 in order
// through a shared bits bus and a one-hot write strobe.
module clb_config_loader #(
    parameter int N_CLB   = 16,
    parameter int FRAME_W = fpga_cfg_pkg::FRAME_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       cfg_valid_i,
    input  logic                       cfg_data_i,
    output logic                       cfg_ready_o,
    output logic [FRAME_W-1:0]         bits_o,
    output logic [N_CLB-1:0]           wr_en_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [$clog2(N_CLB+1)-1:0] frames_ok_o
);

    import fpga_cfg_pkg::*;

    localparam int IDX_W = $clog2(N_CLB);
    localparam int CNT_W = $clog2(N_CLB + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CLB - 1);
    localparam logic [N_CLB-1:0] ONE_HOT_0 = N_CLB'(1);

    loader_state_e      r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [N_CLB-1:0]   r_wr_en;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [CNT_W-1:0]   r_frames_ok;

    logic               w_bit_en;
    logic               w_frame_complete;
    logic               w_parity_ok;
    logic [FRAME_W-1:0] w_frame;

    // r_ready is high exactly in SHIFT, so this is the transfer qualifier
    assign w_bit_en = cfg_valid_i & r_ready;

    cfg_frame_shifter #(
        .FRAME_W (FRAME_W)
    ) u_shifter (
        .clk              (clk),
        .rst              (rst),
        .i_bit_en         (w_bit_en),
        .i_bit            (cfg_data_i),
        .o_frame          (w_frame),
        .o_frame_complete (w_frame_complete),
        .o_parity_ok      (w_parity_ok)
    );

    // Load sequencing FSM with all status outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_wr_en     <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_frames_ok <= '0;
        end else begin
            // NOTE: the strobe defaults low every cycle, so it can only ever
            // be high for the single cycle spent in WRITE.
            r_wr_en <= '0;
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start_i) begin
                        r_state     <= SHIFT;
                        r_idx       <= '0;
                        r_frames_ok <= '0;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_frame_complete) begin
                        r_ready <= 1'b0;
                        if (w_parity_ok) begin
                            r_state     <= WRITE;
                            r_wr_en     <= ONE_HOT_0 << r_idx;
                            r_frames_ok <= r_frames_ok + 1'b1;
                        end else begin
                            r_state <= ERROR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= SHIFT;
                        r_idx   <= r_idx + 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o = r_ready;
    assign bits_o      = w_frame;
    assign wr_en_o     = r_wr_en;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign frames_ok_o = r_frames_ok;

endmodule

// File: tb/tb_clb_config_loader.sv
// Self-checking bench for clb_config_loader (N_CLB=4). Each load is
// described as a list of frames plus an optional bad-parity index; the
// reference model derives the expected strobe sequence and final status
// from that description directly.
module tb_clb_config_loader;

    localparam int N  = 4;
    localparam int FW = fpga_cfg_pkg::FRAME_W;
    localparam int CW = $clog2(N + 1);

    typedef logic [FW-1:0] frame_arr_t [N];

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          cfg_valid_i;
    logic          cfg_data_i;
    logic          cfg_ready_o;
    logic [FW-1:0] bits_o;
    logic [N-1:0]  wr_en_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [CW-1:0] frames_ok_o;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0]  obs_wr[$];
    logic [FW-1:0] obs_bits[$];

    frame_arr_t clean = '{23'h400001, 23'h7FFFFF, 23'h000000, 23'h2AAAAA};

    clb_config_loader #(
        .N_CLB   (N),
        .FRAME_W (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_data_i  (cfg_data_i),
        .cfg_ready_o (cfg_ready_o),
        .bits_o      (bits_o),
        .wr_en_o     (wr_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .frames_ok_o (frames_ok_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every strobe cycle; a strobe must be one-hot
    always @(negedge clk) begin
        if (wr_en_o != '0) begin
            obs_wr.push_back(wr_en_o);
            obs_bits.push_back(bits_o);
            check("strobe_onehot", 32'($onehot(wr_en_o)), 32'd1);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
        check({tag, "_bits"}, 32'(bits_o), 32'd0);
        check({tag, "_ready"}, 32'(cfg_ready_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_frames_ok"}, 32'(frames_ok_o), 32'd0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Offer one bit and hold it until the loader accepts it (bounded)
    task automatic send_bit(input logic b, input logic s);
        int guard = 0;
        cfg_valid_i = 1'b1;
        cfg_data_i  = b;
        start_i     = s;
        while (!cfg_ready_o && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!cfg_ready_o) check("ready_timeout", 32'(cfg_ready_o), 32'd1);
        @(negedge clk);
        cfg_valid_i = 1'b0;
        start_i     = 1'b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] f, input logic bad, input int max_gap, input int mid_bit);
        logic par;
        par = ~(^f) ^ bad;
        for (int i = FW - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_bit(f[i], (FW - 1 - i) == mid_bit);
        end
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        send_bit(par, 1'b0);
    endtask

    // Run one load and compare against the expected outcome of its description
    task automatic run_load(input frame_arr_t fr, input int bad_idx, input int max_gap,
                            input logic mid_start, input string tag);
        int n_ok;
        int guard;
        n_ok = (bad_idx < 0) ? N : bad_idx;
        obs_wr.delete();
        obs_bits.delete();
        pulse_start();
        check({tag, "_start_ready"}, 32'(cfg_ready_o), 32'd1);
        check({tag, "_start_busy"}, 32'(busy_o), 32'd1);
        for (int k = 0; k < N; k++) begin
            send_frame(fr[k], k == bad_idx, max_gap, (mid_start && k == 1) ? 5 : -1);
            if (k == bad_idx) break;
        end
        guard = 0;
        while (!(done_o || err_o) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_finished"}, 32'(done_o | err_o), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_n_strobes"}, 32'(obs_wr.size()), 32'(n_ok));
        for (int i = 0; i < n_ok; i++) begin
            if (i < obs_wr.size()) begin
                check($sformatf("%s_wr_en%0d", tag, i), 32'(obs_wr[i]), 32'(1 << i));
                check($sformatf("%s_bits%0d", tag, i), 32'(obs_bits[i]), 32'(fr[i]));
            end
        end
        check({tag, "_done"}, 32'(done_o), 32'(bad_idx < 0));
        check({tag, "_err"}, 32'(err_o), 32'(bad_idx >= 0));
        check({tag, "_frames_ok"}, 32'(frames_ok_o), 32'(n_ok));
        check({tag, "_ready_end"}, 32'(cfg_ready_o), 32'd0);
        check({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        frame_arr_t rnd;
        int bad;

        rst = 1'b1;
        start_i = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_data_i = 1'b1;

        // Reset held two cycles while valid toggles, then idle toggling
        repeat (2) begin
            @(negedge clk);
            cfg_valid_i = ~cfg_valid_i;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cfg_valid_i = ~cfg_valid_i;
        end
        cfg_valid_i = 1'b0;
        check_all_zero("reset");

        // Clean load, back-to-back bits, then the same stream with gaps
        run_load(clean, -1, 0, 1'b0, "clean");
        run_load(clean, -1, 3, 1'b0, "gapped");

        // Bad parity on frame 2
        run_load(clean, 2, 1, 1'b0, "badpar");
        repeat (5) @(negedge clk);
        check("badpar_ready_hold", 32'(cfg_ready_o), 32'd0);
        check("badpar_err_hold", 32'(err_o), 32'd1);

        // Reset after 10 bits of frame 1
        obs_wr.delete();
        obs_bits.delete();
        pulse_start();
        send_frame(clean[0], 1'b0, 0, -1);
        for (int i = 0; i < 10; i++) send_bit(clean[1][FW - 1 - i], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        check("midrst_prior_strobes", 32'(obs_wr.size()), 32'd1);
        run_load(clean, -1, 1, 1'b0, "after_rst");

        // start_i pulsed mid-SHIFT is ignored
        run_load(clean, -1, 2, 1'b1, "midstart");

        // start_i in DONE restarts the load
        pulse_start();
        check("restart_done", 32'(done_o), 32'd0);
        check("restart_frames_ok", 32'(frames_ok_o), 32'd0);
        check("restart_ready", 32'(cfg_ready_o), 32'd1);
        check("restart_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Random frames, random gaps, occasional parity error
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) rnd[k] = FW'($urandom);
            bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            run_load(rnd, bad, 3, 1'b0, $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
